// File: rtl/hypercpu_pkg.sv
// ---------------------------------------------------------------------------
// hypercpu_pkg
// Shared types and constants for the HyperCPU instruction-fetch slice:
//   word_t           - 32-bit machine word / word address
//   fetch_state_e    - fetch-control FSM states (BOOT, RUN, HALTED)
//   fetch_entry_t    - one fetch-queue entry {instruction word, its address}
//   DEFAULT_RESET_PC - default reset vector
//   next_pc()        - sequential word-address increment (wraps at 2^32)
// ---------------------------------------------------------------------------
package hypercpu_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    typedef struct packed {
        word_t data;
        word_t pc;
    } fetch_entry_t;

    localparam word_t        DEFAULT_RESET_PC = 32'h0000_0000;
    localparam fetch_entry_t ENTRY_ZERO       = '{data: 32'h0000_0000, pc: 32'h0000_0000};

    // Sequential fetch address; 32'hFFFF_FFFF rolls over to 32'h0000_0000.
    function automatic word_t next_pc(input word_t pc);
        return pc + 32'd1;
    endfunction

endpackage

// File: rtl/hypercpu_fetch_queue.sv
// ---------------------------------------------------------------------------
// hypercpu_fetch_queue
// Small in-order queue of fetched instructions. Entry 0 is always the head,
// so the head is read straight from a register. A pop and a push may happen
// in the same cycle even when full, which keeps a depth-1 queue at one
// instruction per cycle.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   flush       - discard every entry at the next edge
//   push        - write push_entry behind the current contents
//   push_entry  - {data, pc} to enqueue
//   pop         - remove the head (ignored when empty)
//   head        - current head entry
//   full, empty - occupancy flags
// ---------------------------------------------------------------------------
module hypercpu_fetch_queue
    import hypercpu_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ZERO_C  = CW'(0);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    fetch_entry_t  entries_r   [DEPTH];
    fetch_entry_t  entries_n_s [DEPTH];
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_n_s;
    logic          pop_s;
    logic          push_s;

    assign empty = (count_r == ZERO_C);
    assign full  = (count_r == DEPTH_C);
    assign head  = entries_r[0];

    // Qualify requests: pop needs data, push needs room (or a same-cycle pop)
    always_comb begin
        pop_s  = pop && !empty;
        push_s = push && (!full || pop_s);
    end

    // Next queue contents: shift toward the head on pop, then append on push
    always_comb begin
        entries_n_s = entries_r;
        count_n_s   = count_r;
        if (pop_s) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                entries_n_s[i] = entries_r[i + 1];
            end
            count_n_s = count_r - ONE_C;
        end else begin
            count_n_s = count_r;
        end
        if (push_s) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == count_n_s) begin
                    entries_n_s[i] = push_entry;
                end else begin
                    entries_n_s[i] = entries_n_s[i];
                end
            end
            count_n_s = count_n_s + ONE_C;
        end else begin
            count_n_s = count_n_s;
        end
    end

    // Queue storage and occupancy; reset and flush both empty the queue
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count_r <= ZERO_C;
            for (int i = 0; i < DEPTH; i++) begin
                entries_r[i] <= ENTRY_ZERO;
            end
        end else begin
            count_r   <= count_n_s;
            entries_r <= entries_n_s;
        end
    end

endmodule

// File: rtl/hypercpu_fetch.sv
// ---------------------------------------------------------------------------
// hypercpu_fetch
// Instruction-fetch unit: issues single-cycle word reads, queues the
// returned words with their addresses and hands them to the decoder through
// a valid/ready handshake. Supports redirect (flush + restart) and halt.
// Build option: define HYPERCPU_FETCH_PREFETCH_EN for a 2-entry queue;
// otherwise the queue holds 1 entry.
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   mem_addr           - fetch word address (always equals the pc)
//   mem_read           - read data, same cycle as mem_addr when enabled
//   mem_read_enabled   - a fetch is issued this cycle
//   inst_data, inst_pc - queue head word and its address
//   inst_valid         - queue head valid
//   inst_ready         - decoder accepts the head
//   redirect_valid/pc  - restart fetching at redirect_pc
//   halt_req           - stop fetching
//   halted             - fetch unit is in the HALTED state
// ---------------------------------------------------------------------------
module hypercpu_fetch
    import hypercpu_pkg::*;
#(
    parameter word_t RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_read,
    output logic        mem_read_enabled,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        halted
);

`ifdef HYPERCPU_FETCH_PREFETCH_EN
    localparam int QUEUE_DEPTH = 2;
`else
    localparam int QUEUE_DEPTH = 1;
`endif

    fetch_state_e state_r;
    word_t        pc_r;
    logic         halted_r;
    logic         issue_s;
    logic         transfer_s;
    logic         q_full_s;
    logic         q_empty_s;
    fetch_entry_t q_head_s;
    fetch_entry_t push_entry_s;

    assign transfer_s       = !q_empty_s && inst_ready;
    assign push_entry_s     = '{data: mem_read, pc: pc_r};
    assign mem_addr         = pc_r;
    assign mem_read_enabled = issue_s;
    assign inst_valid       = !q_empty_s;
    assign inst_data        = q_head_s.data;
    assign inst_pc          = q_head_s.pc;
    assign halted           = halted_r;

    // Issue a fetch in RUN when the word has somewhere to go; a redirect or
    // halt request in the same cycle suppresses it
    always_comb begin
        issue_s = 1'b0;
        if (!reset && (state_r == ST_RUN) && !redirect_valid && !halt_req &&
            (!q_full_s || transfer_s)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Fetch-control FSM, program counter and halted flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_BOOT;
            pc_r     <= RESET_PC;
            halted_r <= 1'b0;
        end else if (redirect_valid) begin
            // Redirect beats halt_req and leaves any state for RUN
            state_r  <= ST_RUN;
            pc_r     <= redirect_pc;
            halted_r <= 1'b0;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    state_r  <= ST_RUN;
                    halted_r <= 1'b0;
                end
                ST_RUN: begin
                    if (halt_req) begin
                        state_r  <= ST_HALTED;
                        halted_r <= 1'b1;
                    end else begin
                        state_r  <= ST_RUN;
                        halted_r <= 1'b0;
                    end
                    if (issue_s) begin
                        pc_r <= next_pc(pc_r);
                    end
                end
                ST_HALTED: begin
                    state_r  <= ST_HALTED;
                    halted_r <= 1'b1;
                end
                default: begin
                    state_r  <= ST_BOOT;
                    halted_r <= 1'b0;
                end
            endcase
        end
    end

    // A pop coinciding with a redirect flush still completes: the decoder
    // has taken the head in that same cycle
    hypercpu_fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (issue_s),
        .push_entry (push_entry_s),
        .pop        (transfer_s),
        .head       (q_head_s),
        .full       (q_full_s),
        .empty      (q_empty_s)
    );

endmodule

// File: tb/tb_hypercpu_fetch.sv
// ---------------------------------------------------------------------------
// tb_hypercpu_fetch
// Directed bench for hypercpu_fetch. Memory returns addr + 32'h100 while
// mem_read_enabled is high and a marker word otherwise. A second instance
// with RESET_PC = 32'hFFFF_FFFF shares the stimulus to show address wrap.
// Inputs change on the falling edge; outputs are checked 1 ns later.
// ---------------------------------------------------------------------------
module tb_hypercpu_fetch;

`ifdef HYPERCPU_FETCH_PREFETCH_EN
    localparam int D = 2;
`else
    localparam int D = 1;
`endif

    logic        clk;
    logic        reset;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;

    logic [31:0] mem_addr, mem_read, inst_data, inst_pc;
    logic        mem_read_enabled, inst_valid, halted;
    logic [31:0] mem_addr_hi, mem_read_hi, inst_data_hi, inst_pc_hi;
    logic        mem_read_enabled_hi, inst_valid_hi, halted_hi;

    int n_tests;
    int n_fail;

    assign mem_read    = mem_read_enabled    ? (mem_addr    + 32'h100) : 32'hDEAD_BEEF;
    assign mem_read_hi = mem_read_enabled_hi ? (mem_addr_hi + 32'h100) : 32'hDEAD_BEEF;

    hypercpu_fetch dut (
        .clk              (clk),
        .reset            (reset),
        .mem_addr         (mem_addr),
        .mem_read         (mem_read),
        .mem_read_enabled (mem_read_enabled),
        .inst_data        (inst_data),
        .inst_pc          (inst_pc),
        .inst_valid       (inst_valid),
        .inst_ready       (inst_ready),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .halt_req         (halt_req),
        .halted           (halted)
    );

    hypercpu_fetch #(
        .RESET_PC (32'hFFFF_FFFF)
    ) dut_hi (
        .clk              (clk),
        .reset            (reset),
        .mem_addr         (mem_addr_hi),
        .mem_read         (mem_read_hi),
        .mem_read_enabled (mem_read_enabled_hi),
        .inst_data        (inst_data_hi),
        .inst_pc          (inst_pc_hi),
        .inst_valid       (inst_valid_hi),
        .inst_ready       (inst_ready),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .halt_req         (halt_req),
        .halted           (halted_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        reset          = 1'b1;
        inst_ready     = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt_req       = 1'b0;

        // Reset for two edges, then release: first cycle is BOOT
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_valid",  {31'd0, inst_valid},       32'd0);
        chk("rst_re",     {31'd0, mem_read_enabled}, 32'd0);
        chk("rst_halted", {31'd0, halted},           32'd0);
        chk("rst_addr",   mem_addr,                  32'h0);
        chk("rst_addr_hi", mem_addr_hi,              32'hFFFF_FFFF);

        // First fetch in the second cycle after reset
        @(negedge clk); #1;
        chk("f0_re",    {31'd0, mem_read_enabled}, 32'd1);
        chk("f0_addr",  mem_addr,                  32'h0);
        chk("f0_valid", {31'd0, inst_valid},       32'd0);
        chk("f0_addr_hi", mem_addr_hi,             32'hFFFF_FFFF);

        // Streaming at one instruction per cycle
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); #1;
            chk("st_valid", {31'd0, inst_valid},       32'd1);
            chk("st_data",  inst_data,                 32'h100 + 32'(k));
            chk("st_pc",    inst_pc,                   32'(k));
            chk("st_addr",  mem_addr,                  32'(k + 1));
            chk("st_re",    {31'd0, mem_read_enabled}, 32'd1);
            if (k == 0) begin
                chk("wrap_pc_hi",   inst_pc_hi,   32'hFFFF_FFFF);
                chk("wrap_data_hi", inst_data_hi, 32'h0000_00FF);
                chk("wrap_addr_hi", mem_addr_hi,  32'h0000_0000);
            end
        end

        // Decoder stalls for five cycles: head holds, fetch stops at depth
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            inst_ready = 1'b0;
            #1;
            chk("stall_valid", {31'd0, inst_valid}, 32'd1);
            chk("stall_data",  inst_data,           32'h106);
            chk("stall_pc",    inst_pc,             32'd6);
        end
        chk("stall_re",   {31'd0, mem_read_enabled}, 32'd0);
        chk("stall_addr", mem_addr,                  32'(6 + D));

        // Resume: no loss, no duplication
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            inst_ready = 1'b1;
            #1;
            chk("res_data", inst_data,                 32'h106 + 32'(k));
            chk("res_pc",   inst_pc,                   32'(6 + k));
            chk("res_re",   {31'd0, mem_read_enabled}, 32'd1);
            chk("res_addr", mem_addr,                  32'(6 + D + k));
        end

        // Redirect to 32'h0A with a full queue and the decoder stalled
        @(negedge clk);
        inst_ready     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0A;
        #1;
        chk("rd_re",    {31'd0, mem_read_enabled}, 32'd0);
        chk("rd_head",  inst_pc,                   32'd9);
        @(negedge clk);
        redirect_valid = 1'b0;
        inst_ready     = 1'b1;
        #1;
        chk("rd1_valid", {31'd0, inst_valid},       32'd0);
        chk("rd1_re",    {31'd0, mem_read_enabled}, 32'd1);
        chk("rd1_addr",  mem_addr,                  32'h0A);
        @(negedge clk); #1;
        chk("rd2_valid", {31'd0, inst_valid}, 32'd1);
        chk("rd2_pc",    inst_pc,             32'h0A);
        chk("rd2_data",  inst_data,           32'h10A);
        chk("rd2_addr",  mem_addr,            32'h0B);

        // Redirect to 3 so the halt lands at pc = 5
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h3;
        #1;
        chk("rd3_re", {31'd0, mem_read_enabled}, 32'd0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("rd3_valid", {31'd0, inst_valid}, 32'd0);
        chk("rd3_addr",  mem_addr,            32'h3);
        @(negedge clk); #1;
        chk("rd3_pc", inst_pc, 32'h3);

        // Halt pulse at pc = 5: no fetch of 5
        @(negedge clk);
        halt_req   = 1'b1;
        inst_ready = 1'b0;
        #1;
        chk("hlt_re",   {31'd0, mem_read_enabled}, 32'd0);
        chk("hlt_addr", mem_addr,                  32'h5);
        chk("hlt_pc",   inst_pc,                   32'h4);
        @(negedge clk);
        halt_req   = 1'b0;
        inst_ready = 1'b1;
        #1;
        chk("hlt1_halted", {31'd0, halted},           32'd1);
        chk("hlt1_re",     {31'd0, mem_read_enabled}, 32'd0);
        chk("hlt1_valid",  {31'd0, inst_valid},       32'd1);
        chk("hlt1_pc",     inst_pc,                   32'h4);
        @(negedge clk); #1;
        chk("hlt2_valid",  {31'd0, inst_valid},       32'd0);
        chk("hlt2_halted", {31'd0, halted},           32'd1);
        chk("hlt2_re",     {31'd0, mem_read_enabled}, 32'd0);
        chk("hlt2_addr",   mem_addr,                  32'h5);

        // Redirect out of HALTED to 32'h20
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        #1;
        chk("hrd_re", {31'd0, mem_read_enabled}, 32'd0);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        chk("hrd1_halted", {31'd0, halted},           32'd0);
        chk("hrd1_re",     {31'd0, mem_read_enabled}, 32'd1);
        chk("hrd1_addr",   mem_addr,                  32'h20);

        // Halt and redirect together: redirect wins
        @(negedge clk);
        halt_req       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h30;
        #1;
        chk("hrd2_pc",   inst_pc,                   32'h20);
        chk("hrd2_data", inst_data,                 32'h120);
        chk("both_re",   {31'd0, mem_read_enabled}, 32'd0);
        @(negedge clk);
        halt_req       = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk("both_halted", {31'd0, halted},           32'd0);
        chk("both_re1",    {31'd0, mem_read_enabled}, 32'd1);
        chk("both_addr",   mem_addr,                  32'h30);
        chk("both_valid",  {31'd0, inst_valid},       32'd0);

        // Fill the queue, then reset with halt_req high
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            inst_ready = 1'b0;
        end
        #1;
        chk("full_re",    {31'd0, mem_read_enabled}, 32'd0);
        chk("full_valid", {31'd0, inst_valid},       32'd1);
        @(negedge clk);
        reset    = 1'b1;
        halt_req = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        halt_req   = 1'b0;
        inst_ready = 1'b1;
        #1;
        chk("rr_valid",  {31'd0, inst_valid},       32'd0);
        chk("rr_halted", {31'd0, halted},           32'd0);
        chk("rr_re",     {31'd0, mem_read_enabled}, 32'd0);
        chk("rr_addr",   mem_addr,                  32'h0);
        @(negedge clk); #1;
        chk("rr1_re",   {31'd0, mem_read_enabled}, 32'd1);
        chk("rr1_addr", mem_addr,                  32'h0);
        @(negedge clk); #1;
        chk("rr2_valid", {31'd0, inst_valid}, 32'd1);
        chk("rr2_pc",    inst_pc,             32'h0);
        chk("rr2_data",  inst_data,           32'h100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
